// File: rtl/accumulator_control_unit.sv
// ============================================================================
// Module : accumulator_control_unit
// Fetch/decode/execute sequencer for the 16-bit accumulator computer; owns
// PC, IR and ACC, masters the memory port and steers the external ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module accumulator_control_unit #(
    parameter int PC_W     = 12,
    parameter int PC_RESET = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [15:0]     mem_addr,
    output logic [15:0]     mem_wdata,
    output logic            mem_we,
    input  logic [15:0]     mem_rdata,
    output logic [3:0]      alu_opcode,
    output logic [15:0]     alu_a,
    output logic [15:0]     alu_b,
    input  logic [15:0]     alu_result,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     ir,
    output logic [15:0]     acc,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_DECODE     = 3'd3,
        S_EXEC_WAIT  = 3'd4,
        S_HALTED     = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_HALT  = 4'h0;
    localparam logic [3:0] c_OP_LOAD  = 4'h1;
    localparam logic [3:0] c_OP_STORE = 4'h2;
    localparam logic [3:0] c_OP_ADD   = 4'h3;
    localparam logic [3:0] c_OP_SUB   = 4'h4;
    localparam logic [3:0] c_OP_AND   = 4'h5;
    localparam logic [3:0] c_OP_OR    = 4'h6;
    localparam logic [3:0] c_OP_XOR   = 4'h7;
    localparam logic [3:0] c_OP_JUMP  = 4'h8;
    localparam logic [3:0] c_OP_JUMPZ = 4'h9;
    localparam logic [3:0] c_OP_LOADI = 4'hA;
    localparam logic [3:0] c_OP_SHL   = 4'hB;
    localparam logic [3:0] c_OP_SHR   = 4'hC;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_SHL = 4'b0100;
    localparam logic [3:0] c_ALU_SHR = 4'b0101;
    localparam logic [3:0] c_ALU_AND = 4'b1000;
    localparam logic [3:0] c_ALU_OR  = 4'b1001;
    localparam logic [3:0] c_ALU_XOR = 4'b1010;

    state_t            r_state;
    state_t            w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic [15:0]       r_ir;
    logic [15:0]       w_ir_next;
    logic [15:0]       r_acc;
    logic [15:0]       w_acc_next;
    logic              r_illegal;
    logic              w_illegal_next;
    logic              w_we;
    logic [3:0]        w_opc;
    logic [11:0]       w_operand;

    assign w_opc     = r_ir[15:12];
    assign w_operand = r_ir[11:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= PC_W'(PC_RESET);
            r_ir      <= 16'h0000;
            r_acc     <= 16'h0000;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_ir      <= w_ir_next;
            r_acc     <= w_acc_next;
            r_illegal <= w_illegal_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_ir_next      = r_ir;
        w_acc_next     = r_acc;
        w_illegal_next = r_illegal;
        mem_addr       = 16'(r_pc);
        mem_wdata      = r_acc;
        w_we           = 1'b0;
        alu_a          = r_acc;
        alu_b          = 16'h0000;
        alu_opcode     = c_ALU_ADD;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_state_next = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                w_ir_next    = mem_rdata;
                w_pc_next    = r_pc + PC_W'(1);
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                w_state_next = S_FETCH;
                case (w_opc)
                    c_OP_HALT: w_state_next = S_HALTED;
                    c_OP_LOAD, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: begin
                        mem_addr     = {4'h0, w_operand};
                        w_state_next = S_EXEC_WAIT;
                    end
                    c_OP_STORE: begin
                        mem_addr = {4'h0, w_operand};
                        w_we     = 1'b1;
                    end
                    c_OP_JUMP:  w_pc_next = PC_W'(w_operand);
                    c_OP_JUMPZ: begin
                        if (r_acc == 16'h0000) w_pc_next = PC_W'(w_operand);
                    end
                    c_OP_LOADI: w_acc_next = {4'h0, w_operand};
                    c_OP_SHL: begin
                        alu_opcode = c_ALU_SHL;
                        w_acc_next = alu_result;
                    end
                    c_OP_SHR: begin
                        alu_opcode = c_ALU_SHR;
                        w_acc_next = alu_result;
                    end
                    default: begin
                        w_illegal_next = 1'b1;
                        w_state_next   = S_HALTED;
                    end
                endcase
            end
            S_EXEC_WAIT: begin
                // Operand fetched in DECODE arrives here; IR still selects the op.
                alu_b = mem_rdata;
                case (w_opc)
                    c_OP_SUB: alu_opcode = c_ALU_SUB;
                    c_OP_AND: alu_opcode = c_ALU_AND;
                    c_OP_OR:  alu_opcode = c_ALU_OR;
                    c_OP_XOR: alu_opcode = c_ALU_XOR;
                    default:  alu_opcode = c_ALU_ADD;
                endcase
                if (w_opc == c_OP_LOAD) w_acc_next = mem_rdata;
                else                    w_acc_next = alu_result;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A STORE decoded in the reset cycle must not reach memory.
    assign mem_we  = w_we & ~reset;
    assign pc      = r_pc;
    assign ir      = r_ir;
    assign acc     = r_acc;
    assign halted  = (r_state == S_HALTED);
    assign illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_accumulator_control_unit.sv
// ============================================================================
// Module : tb_accumulator_control_unit
// Bench for accumulator_control_unit: directed program table, corner-case
// sequences and random programs against an instruction-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_accumulator_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [11:0] pc;
    logic [15:0] ir, acc;
    logic        halted, illegal;

    accumulator_control_unit #(.PC_W(12), .PC_RESET(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .alu_opcode(alu_opcode), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result), .pc(pc), .ir(ir),
        .acc(acc), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0100: alu_result = alu_a << 1;
            4'b0101: alu_result = alu_a >> 1;
            4'b1000: alu_result = alu_a & alu_b;
            4'b1001: alu_result = alu_a | alu_b;
            4'b1010: alu_result = alu_a ^ alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    // Registered-read memory; 'load' copies the staged image in one cycle.
    logic [15:0] img [4096];
    logic [15:0] mem [4096];
    logic        load = 1'b0;
    int          we_cnt;
    logic [15:0] we_addr, we_data;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 4096; i++) mem[i] <= img[i];
            we_cnt <= 0;
        end else if (mem_we) begin
            mem[mem_addr[11:0]] <= mem_wdata;
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
            we_data <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[11:0]];
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
        img[12'h020] = 16'hFFFF;
        img[12'h021] = 16'h0002;
        img[12'h022] = 16'h0003;
    endtask

    task automatic reset_and_load();
        reset = 1'b1; load = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // start is held through the following FETCH edge, where it must be ignored.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    // Instruction-level reference model
    logic [15:0] ref_mem [4096];
    logic [11:0] ref_pc;
    logic [15:0] ref_acc, ref_ir;
    logic        ref_halt, ref_ill;

    task automatic iss_run(input int max_steps, output int cyc);
        logic [15:0] ins;
        logic [11:0] op;
        int steps;
        steps = 0; cyc = 0;
        while (steps < max_steps && !ref_halt) begin
            ins = ref_mem[ref_pc];
            ref_ir = ins;
            ref_pc = ref_pc + 12'd1;
            op = ins[11:0];
            steps++;
            cyc += 3;
            case (ins[15:12])
                4'h0: ref_halt = 1'b1;
                4'h1: begin ref_acc = ref_mem[op]; cyc++; end
                4'h2: ref_mem[op] = ref_acc;
                4'h3: begin ref_acc = ref_acc + ref_mem[op]; cyc++; end
                4'h4: begin ref_acc = ref_acc - ref_mem[op]; cyc++; end
                4'h5: begin ref_acc = ref_acc & ref_mem[op]; cyc++; end
                4'h6: begin ref_acc = ref_acc | ref_mem[op]; cyc++; end
                4'h7: begin ref_acc = ref_acc ^ ref_mem[op]; cyc++; end
                4'h8: ref_pc = op;
                4'h9: if (ref_acc == 16'h0) ref_pc = op;
                4'hA: ref_acc = {4'h0, op};
                4'hB: ref_acc = ref_acc << 1;
                4'hC: ref_acc = ref_acc >> 1;
                default: begin ref_ill = 1'b1; ref_halt = 1'b1; end
            endcase
        end
    endtask

    typedef struct packed {
        logic [5:0][15:0] prog;
        logic [15:0]      acc;
        logic [11:0]      pc;
        logic             ill;
        logic [7:0]       cyc;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3, p4, p5,
                                input logic [15:0] a, input logic [11:0] p,
                                input logic il, input logic [7:0] c);
        vec_t v;
        v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2;
        v.prog[3] = p3; v.prog[4] = p4; v.prog[5] = p5;
        v.acc = a; v.pc = p; v.ill = il; v.cyc = c;
        return v;
    endfunction

    vec_t tbl [8];

    initial begin
        int   cyc;
        int   diffs;
        int   sel;
        logic [3:0]  opc;
        logic [11:0] opr;

        tbl[0] = mk(16'hA005, 16'h2010, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0005, 12'd3, 1'b0, 8'd9);
        tbl[1] = mk(16'h1020, 16'h3021, 16'h4022, 16'h0000, 16'h0, 16'h0, 16'hFFFE, 12'd4, 1'b0, 8'd15);
        tbl[2] = mk(16'h9007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 12'd8, 1'b0, 8'd6);
        tbl[3] = mk(16'hA001, 16'h9007, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0001, 12'd3, 1'b0, 8'd9);
        tbl[4] = mk(16'hE000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 12'd1, 1'b1, 8'd3);
        tbl[5] = mk(16'hA0F0, 16'hB000, 16'hC000, 16'hC000, 16'h0000, 16'h0, 16'h0078, 12'd5, 1'b0, 8'd15);
        tbl[6] = mk(16'h1020, 16'h5021, 16'h6022, 16'h7021, 16'h0000, 16'h0, 16'h0001, 12'd5, 1'b0, 8'd19);
        tbl[7] = mk(16'h8004, 16'hA111, 16'h0000, 16'h0000, 16'hA022, 16'h0000, 16'h0022, 12'd6, 1'b0, 8'd9);

        // Reset state
        clear_img();
        reset_and_load();
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_acc", acc, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_we", mem_we, 0);
        step(4);
        check("idle_no_fetch_pc", pc, 0);

        // Directed program table
        for (int t = 0; t < 8; t++) begin
            clear_img();
            for (int w = 0; w < 6; w++) img[w] = tbl[t].prog[w];
            reset_and_load();
            do_start();
            step(int'(tbl[t].cyc) - 1);
            check($sformatf("tbl%0d_not_yet_halted", t), halted, 0);
            step(1);
            check($sformatf("tbl%0d_acc", t), acc, tbl[t].acc);
            check($sformatf("tbl%0d_pc", t), pc, tbl[t].pc);
            check($sformatf("tbl%0d_halted", t), halted, 1);
            check($sformatf("tbl%0d_illegal", t), illegal, tbl[t].ill);
            if (t == 0) begin
                check("store_pulses", we_cnt, 1);
                check("store_addr", we_addr, 16'h0010);
                check("store_data", we_data, 16'h0005);
                check("store_mem", mem[12'h010], 16'h0005);
            end
        end

        // JUMPZ taken / not taken: next fetch address
        clear_img(); img[0] = 16'h9007;
        reset_and_load(); do_start(); step(3);
        check("jumpz_taken_addr", mem_addr, 16'h0007);
        clear_img(); img[0] = 16'hA001; img[1] = 16'h9007;
        reset_and_load(); do_start(); step(6);
        check("jumpz_fall_addr", mem_addr, 16'h0002);

        // Illegal opcode, then resume
        clear_img(); img[0] = 16'hA033; img[1] = 16'hE000; img[2] = 16'hA055;
        reset_and_load(); do_start(); step(6);
        check("ill_flag", illegal, 1);
        check("ill_halted", halted, 1);
        check("ill_acc_kept", acc, 16'h0033);
        check("ill_pc", pc, 2);
        do_start(); step(6);
        check("resume_acc", acc, 16'h0055);
        check("resume_pc", pc, 4);
        check("resume_ill_sticky", illegal, 1);

        // Reset during EXEC_WAIT of a LOAD
        clear_img(); img[0] = 16'h1020;
        reset_and_load(); do_start(); step(3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstx_acc", acc, 0);
        check("rstx_pc", pc, 0);
        check("rstx_ir", ir, 0);
        check("rstx_we", mem_we, 0);
        check("rstx_halted", halted, 0);
        step(5);
        check("rstx_no_fetch_ir", ir, 0);
        check("rstx_no_fetch_pc", pc, 0);

        // Reset sampled during DECODE of a STORE issues no write
        clear_img(); img[0] = 16'h2010;
        reset_and_load(); do_start(); step(2);
        check("store_we_high", mem_we, 1);
        reset = 1'b1; #1;
        check("store_we_gated", mem_we, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("store_abort_cnt", we_cnt, 0);

        // PC wrap 0xFFF -> 0x000
        clear_img(); img[0] = 16'h8FFF; img[12'hFFF] = 16'hA0AB;
        reset_and_load(); do_start(); step(6);
        check("wrap_acc", acc, 16'h00AB);
        check("wrap_pc", pc, 0);
        check("wrap_addr", mem_addr, 16'h0000);

        // Random programs against the instruction-level model
        for (int r = 0; r < 30; r++) begin
            clear_img();
            for (int i = 0; i < 16; i++) begin
                sel = $urandom_range(0, 14);
                opc = (sel == 13) ? 4'hD : (sel == 14) ? 4'hF : sel[3:0];
                if (opc >= 4'h1 && opc <= 4'h7)      opr = 12'h100 + 12'($urandom_range(0, 15));
                else if (opc == 4'h8 || opc == 4'h9) opr = 12'($urandom_range(0, 15));
                else                                 opr = 12'($urandom_range(0, 4095));
                img[i] = {opc, opr};
                img[12'h100 + i] = 16'($urandom);
            end
            ref_mem = img;
            ref_pc = 12'h0; ref_acc = 16'h0; ref_ir = 16'h0;
            ref_halt = 1'b0; ref_ill = 1'b0;
            iss_run(25, cyc);
            reset_and_load(); do_start(); step(cyc);
            check($sformatf("rnd%0d_pc", r), pc, ref_pc);
            check($sformatf("rnd%0d_acc", r), acc, ref_acc);
            check($sformatf("rnd%0d_ir", r), ir, ref_ir);
            check($sformatf("rnd%0d_halted", r), halted, ref_halt);
            check($sformatf("rnd%0d_illegal", r), illegal, ref_ill);
            diffs = 0;
            for (int i = 0; i < 16; i++)
                if (mem[12'h100 + i] !== ref_mem[12'h100 + i]) diffs++;
            check($sformatf("rnd%0d_mem_diffs", r), diffs, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
